// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : divider_arbiter
// Brief   : Round-robin arbiter sharing one external divider between two requesters.
// Rev     : 1.0  initial release
// ============================================================================
module divider_arbiter #(
  parameter bit RESET_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        req0Valid,
  output logic        req0Ready,
  input  logic [31:0] req0Left,
  input  logic [31:0] req0Right,
  input  logic        req0Signed,
  input  logic        req0Remainder,
  output logic        resp0Valid,
  input  logic        resp0Ack,
  output logic [31:0] resp0Result,
  output logic        resp0DivByZero,
  input  logic        req1Valid,
  output logic        req1Ready,
  input  logic [31:0] req1Left,
  input  logic [31:0] req1Right,
  input  logic        req1Signed,
  input  logic        req1Remainder,
  output logic        resp1Valid,
  input  logic        resp1Ack,
  output logic [31:0] resp1Result,
  output logic        resp1DivByZero,
  output logic [31:0] divLeft,
  output logic [31:0] divRight,
  output logic        divSigned,
  output logic        divActivate,
  input  logic        divDone,
  input  logic [31:0] divQuotient,
  input  logic [31:0] divRemainder,
  input  logic        divDivByZero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    BUSY    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_prio;
  logic        r_id;
  logic        r_signed;
  logic        r_rem;
  logic        r_dbz;
  logic        r_activate;
  logic [1:0]  r_resp_valid;
  logic [31:0] r_left;
  logic [31:0] r_right;
  logic [31:0] r_result;

  logic w_grant;
  logic w_accept;
  logic w_ack;

  // Ready is also forced low while reset is held so every handshake output is quiet in reset.
  assign w_grant   = (req0Valid && req1Valid) ? r_prio : req1Valid;
  assign req0Ready = resetN && (r_state == IDLE) && req0Valid && !w_grant;
  assign req1Ready = resetN && (r_state == IDLE) && req1Valid && w_grant;
  assign w_accept  = req0Ready || req1Ready;
  assign w_ack     = (r_resp_valid[0] && resp0Ack) || (r_resp_valid[1] && resp1Ack);

  assign divLeft     = r_left;
  assign divRight    = r_right;
  assign divSigned   = r_signed;
  assign divActivate = r_activate;

  assign resp0Valid     = r_resp_valid[0];
  assign resp0Result    = r_resp_valid[0] ? r_result : '0;
  assign resp0DivByZero = r_resp_valid[0] && r_dbz;
  assign resp1Valid     = r_resp_valid[1];
  assign resp1Result    = r_resp_valid[1] ? r_result : '0;
  assign resp1DivByZero = r_resp_valid[1] && r_dbz;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_prio       <= RESET_PRIORITY;
      r_id         <= 1'b0;
      r_signed     <= 1'b0;
      r_rem        <= 1'b0;
      r_dbz        <= 1'b0;
      r_activate   <= 1'b0;
      r_resp_valid <= 2'b00;
      r_left       <= '0;
      r_right      <= '0;
      r_result     <= '0;
    end else begin
      r_activate <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id       <= w_grant;
            r_prio     <= !w_grant;
            r_left     <= w_grant ? req1Left      : req0Left;
            r_right    <= w_grant ? req1Right     : req0Right;
            r_signed   <= w_grant ? req1Signed    : req0Signed;
            r_rem      <= w_grant ? req1Remainder : req0Remainder;
            r_activate <= 1'b1;
            r_state    <= START;
          end
        end
        START: r_state <= BUSY;
        // divDone is only trusted here; earlier it still reflects the previous operation.
        BUSY: begin
          if (divDone) begin
            r_result     <= r_rem ? divRemainder : divQuotient;
            r_dbz        <= divDivByZero;
            r_resp_valid <= r_id ? 2'b10 : 2'b01;
            r_state      <= RESPOND;
          end
        end
        RESPOND: begin
          if (w_ack) begin
            r_resp_valid <= 2'b00;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider_arbiter
// Brief   : Self-checking bench for divider_arbiter with a 32-cycle divider model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_divider_arbiter;

  logic        clock  = 1'b0;
  logic        resetN = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_signed = 2'b00;
  logic [1:0]  req_rem = 2'b00;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ack = 2'b00;
  logic [1:0]  resp_dbz;
  logic [31:0] req_left[2];
  logic [31:0] req_right[2];
  logic [31:0] resp_result[2];
  logic [31:0] divLeft, divRight;
  logic        divSigned, divActivate;
  logic        divDone = 1'b1;
  logic [31:0] divQuotient = 32'hDEAD_BEEF;
  logic [31:0] divRemainder = 32'h0BAD_F00D;
  logic        divDivByZero = 1'b1;

  always #5 clock = ~clock;

  divider_arbiter #(.RESET_PRIORITY(1'b0)) dut (
    .clock(clock), .resetN(resetN),
    .req0Valid(req_valid[0]), .req0Ready(req_ready[0]),
    .req0Left(req_left[0]), .req0Right(req_right[0]),
    .req0Signed(req_signed[0]), .req0Remainder(req_rem[0]),
    .resp0Valid(resp_valid[0]), .resp0Ack(resp_ack[0]),
    .resp0Result(resp_result[0]), .resp0DivByZero(resp_dbz[0]),
    .req1Valid(req_valid[1]), .req1Ready(req_ready[1]),
    .req1Left(req_left[1]), .req1Right(req_right[1]),
    .req1Signed(req_signed[1]), .req1Remainder(req_rem[1]),
    .resp1Valid(resp_valid[1]), .resp1Ack(resp_ack[1]),
    .resp1Result(resp_result[1]), .resp1DivByZero(resp_dbz[1]),
    .divLeft(divLeft), .divRight(divRight), .divSigned(divSigned),
    .divActivate(divActivate), .divDone(divDone),
    .divQuotient(divQuotient), .divRemainder(divRemainder),
    .divDivByZero(divDivByZero)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } div_t;

  // Arithmetic definition of the divider: x/0 gives all-ones and remainder = dividend.
  function automatic div_t ref_div(input logic [31:0] l, input logic [31:0] r, input logic s);
    div_t d;
    d.z = (r == 32'd0);
    if (r == 32'd0) begin
      d.q = 32'hFFFF_FFFF;
      d.r = l;
    end else if (s && l == 32'h8000_0000 && r == 32'hFFFF_FFFF) begin
      d.q = l;
      d.r = 32'd0;
    end else if (s) begin
      d.q = $signed(l) / $signed(r);
      d.r = $signed(l) % $signed(r);
    end else begin
      d.q = l / r;
      d.r = l % r;
    end
    return d;
  endfunction

  // Shared divider: done rises 32 edges after the edge that samples divActivate and stays high.
  int   dcnt = 0;
  div_t pend;
  always @(posedge clock) begin
    if (divActivate) begin
      dcnt    <= 32;
      divDone <= 1'b0;
      pend    <= ref_div(divLeft, divRight, divSigned);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        divDone      <= 1'b1;
        divQuotient  <= pend.q;
        divRemainder <= pend.r;
        divDivByZero <= pend.z;
      end
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        pref     = 1'b0;
  logic [31:0] got_res;
  logic        got_dbz;
  int          last_wait;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction; the winner is predicted from the round-robin rule.
  task automatic run_op(input logic [1:0] mask, input int delay, input bit hold,
                        input bit keep, input bit rereq, input string name);
    int w, o, lat, pulses, busy_rdy, bad;
    div_t e;
    logic [31:0] er;
    w  = (mask == 2'b11) ? int'(pref) : ((mask == 2'b10) ? 1 : 0);
    o  = 1 - w;
    e  = ref_div(req_left[w], req_right[w], req_signed[w]);
    er = req_rem[w] ? e.r : e.q;
    req_valid = mask;
    #1;
    last_wait = 0;
    while (req_ready == 2'b00 && last_wait < 50) begin
      tick();
      last_wait++;
    end
    check({name, " grant"}, 32'(req_ready), 1 << w);
    tick();
    req_valid = keep ? (req_valid & ~(2'(1) << w)) : 2'b00;
    pref = (w == 0);
    lat = 0; pulses = 0; busy_rdy = 0;
    while (resp_valid == 2'b00 && lat < 60) begin
      if (divActivate) pulses++;
      if (req_ready != 2'b00) busy_rdy++;
      resp_ack[w] = ($urandom_range(0, 3) == 0);
      tick();
      lat++;
    end
    resp_ack = 2'b00;
    check({name, " latency"}, lat, 34);
    check({name, " activate pulses"}, pulses, 1);
    check({name, " ready while busy"}, busy_rdy, 0);
    check({name, " resp valid"}, 32'(resp_valid), 1 << w);
    got_res = resp_result[w];
    got_dbz = resp_dbz[w];
    check({name, " result"}, got_res, er);
    check({name, " divbyzero"}, 32'(got_dbz), 32'(e.z));
    check({name, " other result"}, resp_result[o], 32'd0);
    bad = 0;
    for (int k = 0; k < delay; k++) begin
      if (hold) begin
        req_valid[o] = 1'b1;
        resp_ack[o]  = 1'b1;
        #1;
      end
      if (req_ready != 2'b00 || divActivate || resp_valid != (2'(1) << w) ||
          resp_result[w] !== got_res) bad++;
      tick();
    end
    if (delay > 0) check({name, " hold stable"}, bad, 0);
    if (hold) req_valid[o] = 1'b0;
    if (rereq) req_valid[w] = 1'b1;
    resp_ack = 2'(1) << w;
    tick();
    resp_ack = 2'b00;
    check({name, " valid after ack"}, 32'(resp_valid), 32'd0);
    check({name, " result after ack"}, resp_result[w], 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] l;
    logic [31:0] r;
    logic        s;
    logic        m;
    logic [31:0] res;
    logic        z;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         1'b0};
    vecs[1] = '{1, 32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{0, 32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1'b1};
    vecs[3] = '{1, 32'd5,          32'd0,          1'b0, 1'b1, 32'd5,          1'b1};
    vecs[4] = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  1'b0};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd3,          1'b0, 1'b0, 32'h5555_5555,  1'b0};
    vecs[6] = '{0, 32'hFFFF_FF9C,  32'd7,          1'b1, 1'b1, 32'hFFFF_FFFE,  1'b0};
    vecs[7] = '{1, 32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD,  1'b0};

    // Reset state with both requesters already pending.
    req_left[0] = 32'd100;        req_right[0] = 32'd7; req_signed[0] = 1'b0; req_rem[0] = 1'b0;
    req_left[1] = 32'hFFFF_FFF9;  req_right[1] = 32'd2; req_signed[1] = 1'b1; req_rem[1] = 1'b1;
    req_valid = 2'b11;
    #12;
    check("reset ready", 32'(req_ready), 32'd0);
    check("reset resp valid", 32'(resp_valid), 32'd0);
    check("reset activate", 32'(divActivate), 32'd0);
    check("reset result0", resp_result[0], 32'd0);
    check("reset divLeft", divLeft, 32'd0);

    // Simultaneous requests: req0 first, req1 one cycle after ack, re-requesting req0 loses.
    @(posedge clock); #1;
    resetN = 1'b1;
    run_op(2'b11, 0, 1'b0, 1'b1, 1'b1, "arb req0");
    check("arb first accept wait", last_wait, 0);
    check("arb 100/7 result", got_res, 32'd14);
    check("arb ready after ack", 32'(req_ready), 32'h2);
    run_op(2'b11, 0, 1'b0, 1'b1, 1'b0, "arb req1");
    check("arb req1 accept wait", last_wait, 0);
    check("arb -7/2 rem", got_res, 32'hFFFF_FFFF);
    run_op(2'b01, 0, 1'b0, 1'b0, 1'b0, "arb req0 again");

    // Reset in the middle of BUSY abandons the operation.
    req_left[0] = 32'd77; req_right[0] = 32'd3; req_signed[0] = 1'b0; req_rem[0] = 1'b0;
    req_valid = 2'b01;
    #1;
    check("rst ready before accept", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    repeat (10) tick();
    #2 resetN = 1'b0;
    #1;
    check("rst async outputs", {28'd0, resp_valid, divActivate, |req_ready}, 32'd0);
    check("rst async divLeft", divLeft, 32'd0);
    @(posedge clock); #1;
    resetN = 1'b1;
    pref = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (resp_valid != 2'b00) seen++;
        tick();
      end
      check("rst no response", seen, 0);
    end
    req_left[0] = 32'd1000; req_right[0] = 32'd10;
    run_op(2'b01, 0, 1'b0, 1'b0, 1'b0, "post-reset 1000/10");
    check("post-reset result", got_res, 32'd100);

    // Ack withheld for 10 cycles while the other requester is pending.
    req_left[1] = 32'd1234; req_right[1] = 32'd10; req_signed[1] = 1'b0; req_rem[1] = 1'b1;
    run_op(2'b10, 10, 1'b1, 1'b0, 1'b0, "ack hold");

    for (int i = 0; i < 8; i++) begin
      req_left[vecs[i].id]   = vecs[i].l;
      req_right[vecs[i].id]  = vecs[i].r;
      req_signed[vecs[i].id] = vecs[i].s;
      req_rem[vecs[i].id]    = vecs[i].m;
      run_op(2'(1) << vecs[i].id, 0, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table result", i), got_res, vecs[i].res);
      check($sformatf("vec%0d table dbz", i), 32'(got_dbz), 32'(vecs[i].z));
    end

    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 2; j++) begin
        req_left[j] = $urandom;
        case ($urandom_range(0, 3))
          0:       req_right[j] = 32'd0;
          1:       req_right[j] = $urandom_range(1, 10);
          2:       req_right[j] = 32'hFFFF_FFFF;
          default: req_right[j] = $urandom;
        endcase
        req_signed[j] = 1'($urandom_range(0, 1));
        req_rem[j]    = 1'($urandom_range(0, 1));
      end
      run_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
